// File: rtl/mcp9808_sched.sv
// rtl/mcp9808_sched.sv - one-at-a-time command scheduler in front of the mcp9808 interface block
module mcp9808_sched #(
    parameter int unsigned POLL_PERIOD = 100000,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter logic [1:0]  RES_INIT    = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    input  logic [10:0] host_T,
    input  logic [1:0]  host_sel,
    input  logic        host_wr,
    input  logic [1:0]  host_res,
    input  logic        host_res_wr,
    input  logic        sleep_req,
    output logic [10:0] if_T_i,
    output logic [1:0]  if_T_write,
    output logic [1:0]  if_res,
    output logic        if_shutdown,
    output logic        if_update,
    input  logic        if_ready,
    input  logic [10:0] if_T_o,
    output logic [10:0] temp,
    output logic        temp_valid,
    output logic [3:0]  pend,
    output logic        busy,
    output logic        timeout_err
);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_PERIOD - 1);
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, SLEEP_ENTER, SLEEP, SLEEP_EXIT} state_t;
    typedef enum logic [2:0] {CMD_CRIT, CMD_UPPER, CMD_LOWER, CMD_RES, CMD_READ} cmd_t;

    state_t         state, state_next;
    cmd_t           cmd, cmd_sel;
    logic           start, accept, done, timeout;
    logic [3:0]     acc_slot;
    logic [WW-1:0]  wd;
    logic [PW-1:0]  poll_cnt;
    logic           poll_due;
    logic [10:0]    val_crit, val_upper, val_lower;
    logic [1:0]     val_res;
    logic           wr_crit, wr_upper, wr_lower;
    logic           wd_run, sleeping;

    assign wr_crit  = host_wr && (host_sel == 2'b11);
    assign wr_upper = host_wr && (host_sel == 2'b10);
    assign wr_lower = host_wr && (host_sel == 2'b01);
    assign wd_run   = state inside {ISSUE, WAIT_DONE, SLEEP_ENTER, SLEEP_EXIT};
    assign sleeping = state inside {SLEEP_ENTER, SLEEP, SLEEP_EXIT};
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        cmd_sel    = CMD_READ;
        start      = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        acc_slot   = 4'b0000;
        case (state)
            IDLE: if (if_ready) begin
                if (sleep_req)      state_next = SLEEP_ENTER;
                else if (pend[2])   begin cmd_sel = CMD_CRIT;  start = 1'b1; end
                else if (pend[1])   begin cmd_sel = CMD_UPPER; start = 1'b1; end
                else if (pend[0])   begin cmd_sel = CMD_LOWER; start = 1'b1; end
                else if (pend[3])   begin cmd_sel = CMD_RES;   start = 1'b1; end
                else if (poll_due)  begin cmd_sel = CMD_READ;  start = 1'b1; end
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                if (!if_ready) begin
                    accept     = 1'b1;
                    state_next = WAIT_DONE;
                end else if (wd == WD_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (if_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (wd == WD_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            SLEEP_ENTER: begin
                if (!if_ready) state_next = SLEEP;
                else if (wd == WD_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            SLEEP: if (!sleep_req) state_next = SLEEP_EXIT;
            SLEEP_EXIT: begin
                if (if_ready) state_next = IDLE;
                else if (wd == WD_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // acceptance retires the slot; a same-cycle host write re-arms it below
        if (accept) begin
            case (cmd)
                CMD_CRIT:  acc_slot[2] = 1'b1;
                CMD_UPPER: acc_slot[1] = 1'b1;
                CMD_LOWER: acc_slot[0] = 1'b1;
                CMD_RES:   acc_slot[3] = 1'b1;
                default:   acc_slot    = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd         <= CMD_READ;
            wd          <= '0;
            poll_cnt    <= POLL_RELOAD;
            poll_due    <= 1'b0;
            pend        <= 4'b0000;
            val_crit    <= '0;
            val_upper   <= '0;
            val_lower   <= '0;
            val_res     <= '0;
            if_T_i      <= '0;
            if_T_write  <= 2'b00;
            if_res      <= RES_INIT;
            if_shutdown <= 1'b0;
            if_update   <= 1'b0;
            temp        <= '0;
            temp_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) wd <= '0;
            else if (wd_run)         wd <= wd + 1'b1;

            pend <= (pend & ~acc_slot) | {host_res_wr, wr_crit, wr_upper, wr_lower};
            if (wr_crit)     val_crit  <= host_T;
            if (wr_upper)    val_upper <= host_T;
            if (wr_lower)    val_lower <= host_T;
            if (host_res_wr) val_res   <= host_res;

            // timer is frozen across the whole sleep sequence
            if (!poll_en) begin
                poll_cnt <= POLL_RELOAD;
                poll_due <= 1'b0;
            end else begin
                if (accept && cmd == CMD_READ) poll_due <= 1'b0;
                if (!sleeping) begin
                    if (poll_cnt == '0) begin
                        poll_cnt <= POLL_RELOAD;
                        poll_due <= 1'b1;
                    end else begin
                        poll_cnt <= poll_cnt - 1'b1;
                    end
                end
            end

            if (start) begin
                cmd <= cmd_sel;
                case (cmd_sel)
                    CMD_CRIT:  begin if_T_write <= 2'b11; if_T_i <= val_crit;  end
                    CMD_UPPER: begin if_T_write <= 2'b10; if_T_i <= val_upper; end
                    CMD_LOWER: begin if_T_write <= 2'b01; if_T_i <= val_lower; end
                    CMD_RES:   if_res <= val_res;
                    default:   if_update <= 1'b1;
                endcase
            end
            if (accept || timeout) begin
                if_T_write <= 2'b00;
                if_update  <= 1'b0;
            end

            if (state == IDLE && state_next == SLEEP_ENTER)
                if_shutdown <= 1'b1;
            else if ((state == SLEEP && state_next == SLEEP_EXIT) || (state == SLEEP_ENTER && timeout))
                if_shutdown <= 1'b0;

            temp_valid <= 1'b0;
            if (done && cmd == CMD_READ) begin
                temp       <= if_T_o;
                temp_valid <= 1'b1;
            end
            if (timeout) timeout_err <= 1'b1;
        end
    end
endmodule
